// File: rtl/alu_seq_unit.sv
// Multi-cycle execute unit: ALU command decode, single-cycle data ops,
// iterative 1-bit/cycle barrel shift and shift-add multiply.
module alu_seq_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     ready,
  input  logic                     alu_op,
  input  logic                     s,
  input  logic [3:0]               cmd,
  input  logic                     mul,
  input  logic [1:0]               sh_type,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         src_a,
  input  logic [WIDTH-1:0]         src_b,
  output logic [WIDTH-1:0]         result,
  output logic [3:0]               flags,
  output logic [1:0]               flag_w,
  output logic                     no_write,
  output logic                     done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_MUL
  } state_t;

  typedef enum logic [2:0] {
    K_ADD, K_SUB, K_AND, K_EOR,
    K_ORR, K_MOV, K_MUL, K_NOP
  } kind_t;

  state_t state_q, state_d;
  kind_t  kind;

  logic [1:0]       fw_d, fw_q, sh_t_q;
  logic             nw_d;
  logic [WIDTH:0]   sum, diff, sh_in, sh_st;
  logic [WIDTH-1:0] res1, val_q, op_a, op_b, mul_nxt;
  logic             c1, v1;
  logic [CW-1:0]    cnt_q;
  logic             accept, multi, fin;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v, fin_nw;
  logic [1:0]       fin_fw;

  // One shift step: returns {bit shifted out, shifted value}
  function automatic logic [WIDTH:0] sh1(
    input logic [1:0]       t,
    input logic [WIDTH-1:0] v
  );
    case (t)
      2'b00:   sh1 = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      2'b01:   sh1 = {v[0], 1'b0, v[WIDTH-1:1]};
      2'b10:   sh1 = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: sh1 = {v[0], v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  assign ready   = (state_q == S_IDLE);
  assign accept  = start & ready;
  assign sum     = {1'b0, src_a} + {1'b0, src_b};
  assign diff    = {1'b0, src_a} - {1'b0, src_b};
  assign sh_in   = sh1(sh_type, src_b);
  assign sh_st   = sh1(sh_t_q, val_q);
  assign mul_nxt = val_q + (op_b[0] ? op_a : '0);
  assign multi   = (kind == K_MUL) ||
                   (kind == K_MOV && shamt > SW'(1));

  always_comb begin
    kind = K_ADD;
    fw_d = 2'b00;
    nw_d = 1'b0;
    if (alu_op) begin
      if (mul && MUL_EN) begin
        kind = K_MUL;
        fw_d = {s, 1'b0};
      end else begin
        unique case (cmd)
          4'b0100: begin kind = K_ADD; fw_d = {s, s}; end
          4'b0010: begin kind = K_SUB; fw_d = {s, s}; end
          4'b0000: begin kind = K_AND; fw_d = {s, 1'b0}; end
          4'b0001: begin kind = K_EOR; fw_d = {s, 1'b0}; end
          4'b1100: begin kind = K_ORR; fw_d = {s, 1'b0}; end
          4'b1101: begin kind = K_MOV; fw_d = {s, 1'b0}; end
          4'b1010: begin kind = K_SUB; fw_d = 2'b11; nw_d = 1'b1; end
          4'b1011: begin kind = K_ADD; fw_d = 2'b11; nw_d = 1'b1; end
          4'b1000: begin kind = K_AND; fw_d = 2'b10; nw_d = 1'b1; end
          default: begin kind = K_NOP; nw_d = 1'b1; end
        endcase
      end
    end
  end

  always_comb begin
    res1 = '0;
    c1   = 1'b0;
    v1   = 1'b0;
    unique case (kind)
      K_ADD: begin
        res1 = sum[WIDTH-1:0];
        c1   = sum[WIDTH];
        v1   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
               (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      K_SUB: begin
        res1 = diff[WIDTH-1:0];
        c1   = ~diff[WIDTH];
        v1   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
               (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      K_AND: res1 = src_a & src_b;
      K_EOR: res1 = src_a ^ src_b;
      K_ORR: res1 = src_a | src_b;
      K_MOV: begin
        if (shamt != '0) {c1, res1} = sh_in;
        else res1 = src_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    fin_res = res1;
    fin_c   = c1;
    fin_v   = v1;
    fin_fw  = fw_d;
    fin_nw  = nw_d;
    unique case (state_q)
      S_IDLE: begin
        fin = accept && !multi;
        if (accept && multi)
          state_d = (kind == K_MUL) ? S_MUL : S_SHIFT;
      end
      S_SHIFT: begin
        fin     = (cnt_q == CW'(1));
        fin_res = sh_st[WIDTH-1:0];
        fin_c   = sh_st[WIDTH];
        fin_v   = 1'b0;
        fin_fw  = fw_q;
        fin_nw  = 1'b0;
        if (fin) state_d = S_IDLE;
      end
      S_MUL: begin
        fin     = (cnt_q == CW'(1));
        fin_res = mul_nxt;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        fin_fw  = fw_q;
        fin_nw  = 1'b0;
        if (fin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      flags    <= '0;
      flag_w   <= '0;
      no_write <= 1'b0;
      done     <= 1'b0;
      val_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      cnt_q    <= '0;
      sh_t_q   <= '0;
      fw_q     <= '0;
    end else begin
      done <= fin;
      if (fin) begin
        result   <= fin_res;
        flags    <= {fin_res[WIDTH-1], fin_res == '0, fin_c, fin_v};
        flag_w   <= fin_fw;
        no_write <= fin_nw;
      end
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            sh_t_q <= sh_type;
            fw_q   <= fw_d;
            op_a   <= src_a;
            op_b   <= src_b;
            if (kind == K_MUL) begin
              val_q <= '0;
              cnt_q <= CW'(WIDTH);
            end else begin
              // first shift step happens on the accept edge
              val_q <= sh_in[WIDTH-1:0];
              cnt_q <= CW'(shamt) - CW'(1);
            end
          end
        end
        S_SHIFT: begin
          val_q <= sh_st[WIDTH-1:0];
          cnt_q <= cnt_q - CW'(1);
        end
        S_MUL: begin
          val_q <= mul_nxt;
          op_a  <= op_a << 1;
          op_b  <= op_b >> 1;
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
